// File: rtl/camera_timing_gen_if.sv
// DVP camera-side bundle: enable/mode controls in, pixel clock, syncs, data and status out.
// Master is the timing generator; slave is the capture path or bench that consumes the stream.
interface camera_timing_gen_if;
    logic       en;
    logic [1:0] mode;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic [9:0] line_idx;
    logic       frame_done;

    modport master (
        input  en, mode,
        output cam_pclk, cam_vsync, cam_href, cam_data, line_idx, frame_done
    );

    modport slave (
        output en, mode,
        input  cam_pclk, cam_vsync, cam_href, cam_data, line_idx, frame_done
    );
endinterface

// File: rtl/camera_timing_gen.sv
// Synthesisable OV7670-style DVP frame generator with selectable test patterns.
// Outputs are registered and change only on byte ticks (cam_pclk falling); there is no backpressure.
module camera_timing_gen #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int BPP         = 2,
    parameter int HBLANK      = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic                clk,
    input  logic                rst,
    camera_timing_gen_if.master cam
);
    localparam int LINE_BYTES = WIDTH * BPP + HBLANK;
    localparam int ACT_BYTES  = WIDTH * BPP;
    localparam int CW         = ($clog2(LINE_BYTES) < 8) ? 8 : $clog2(LINE_BYTES);
    localparam int M1         = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int M2         = (HEIGHT > VFP_LINES) ? HEIGHT : VFP_LINES;
    localparam int MAXL       = (M1 > M2) ? M1 : M2;
    localparam int LW         = ($clog2(MAXL + 1) < 10) ? 10 : $clog2(MAXL + 1);
    localparam int DW         = $clog2(PCLK_DIV);

    localparam logic [DW-1:0] DIV_LAST  = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(PCLK_DIV / 2);
    localparam logic [CW-1:0] BYTE_LAST = CW'(LINE_BYTES - 1);
    localparam logic [CW-1:0] ACT_END   = CW'(ACT_BYTES);
    localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VBP_LAST  = LW'(VBP_LINES - 1);
    localparam logic [LW-1:0] ACT_LAST  = LW'(HEIGHT - 1);
    localparam logic [LW-1:0] VFP_LAST  = LW'(VFP_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    // Zero-length blanking states are skipped entirely, so they are never entered.
    localparam state_t FIRST_ST    = (VSYNC_LINES > 0) ? S_VSYNC :
                                     (VBP_LINES > 0)   ? S_VBP   : S_ACTIVE;
    localparam state_t AFTER_VSYNC = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
    localparam bit     HAS_VFP     = (VFP_LINES > 0);

    state_t          r_state;
    logic [DW-1:0]   r_div_cnt;
    logic [CW-1:0]   r_byte_cnt;
    logic [LW-1:0]   r_line_cnt;
    logic [1:0]      r_mode_q;
    logic [2:0]      r_phase;
    logic            r_pclk;
    logic            r_vsync;
    logic            r_href;
    logic [7:0]      r_data;
    logic [9:0]      r_line_idx;
    logic            r_frame_done;

    state_t          w_state_n;
    logic [DW-1:0]   w_div_nxt;
    logic            w_tick;
    logic            w_last_byte;
    logic            w_last_line;
    logic [CW-1:0]   w_byte_n;
    logic [LW-1:0]   w_line_n;
    logic            w_frame_end;
    logic            w_new_frame;
    logic [1:0]      w_mode_eff;
    logic [2:0]      w_phase_eff;
    logic [2:0]      w_phase_n;
    logic            w_href_n;
    logic [7:0]      w_data_n;
    logic [7:0]      w_seq_byte;

    always_comb begin
        w_tick    = (r_div_cnt == DIV_LAST);
        w_div_nxt = w_tick ? '0 : r_div_cnt + DW'(1);
        w_last_byte = (r_byte_cnt == BYTE_LAST);
        case (r_state)
            S_VSYNC:  w_last_line = (r_line_cnt == VS_LAST);
            S_VBP:    w_last_line = (r_line_cnt == VBP_LAST);
            S_ACTIVE: w_last_line = (r_line_cnt == ACT_LAST);
            S_VFP:    w_last_line = (r_line_cnt == VFP_LAST);
            default:  w_last_line = 1'b0;
        endcase

        w_state_n   = r_state;
        w_byte_n    = r_byte_cnt;
        w_line_n    = r_line_cnt;
        w_frame_end = 1'b0;
        w_new_frame = 1'b0;

        if (w_tick) begin
            if (r_state == S_IDLE) begin
                if (cam.en) begin
                    w_new_frame = 1'b1;
                    w_state_n   = FIRST_ST;
                    w_byte_n    = '0;
                    w_line_n    = '0;
                end
            end else begin
                w_byte_n = w_last_byte ? '0 : r_byte_cnt + CW'(1);
                if (w_last_byte) begin
                    if (w_last_line) begin
                        w_line_n = '0;
                        case (r_state)
                            S_VSYNC:  w_state_n = AFTER_VSYNC;
                            S_VBP:    w_state_n = S_ACTIVE;
                            S_ACTIVE: begin
                                if (HAS_VFP) w_state_n = S_VFP;
                                else         w_frame_end = 1'b1;
                            end
                            S_VFP:    w_frame_end = 1'b1;
                            default:  w_state_n = S_IDLE;
                        endcase
                    end else begin
                        w_line_n = r_line_cnt + LW'(1);
                    end
                end
                // en is only looked at here, so a mid-frame drop lets the frame finish.
                if (w_frame_end) begin
                    w_new_frame = cam.en;
                    w_state_n   = cam.en ? FIRST_ST : S_IDLE;
                end
            end
        end
    end

    always_comb begin
        w_mode_eff  = w_new_frame ? cam.mode : r_mode_q;
        w_phase_eff = w_new_frame ? 3'd0 : r_phase;
        w_href_n    = (w_state_n == S_ACTIVE) && (w_byte_n < ACT_END);

        case (w_phase_eff)
            3'd0:    w_seq_byte = 8'hAA;
            3'd1:    w_seq_byte = 8'h0B;
            3'd2:    w_seq_byte = 8'hAC;
            3'd3:    w_seq_byte = 8'h0D;
            default: w_seq_byte = 8'hAE;
        endcase

        w_phase_n = w_phase_eff;
        if (w_href_n && (w_mode_eff == 2'd1))
            w_phase_n = (w_phase_eff == 3'd4) ? 3'd0 : w_phase_eff + 3'd1;

        w_data_n = 8'h00;
        if (w_href_n) begin
            case (w_mode_eff)
                2'd0:    w_data_n = 8'hFF;
                2'd1:    w_data_n = w_seq_byte;
                2'd2:    w_data_n = w_byte_n[7:0];
                default: w_data_n = w_line_n[7:0] ^ w_byte_n[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_line_cnt   <= '0;
            r_mode_q     <= 2'd0;
            r_phase      <= 3'd0;
            r_pclk       <= 1'b0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_line_idx   <= 10'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_nxt;
            // pclk follows the next div value so its falling edge lines up with the byte tick.
            r_pclk       <= (w_state_n != S_IDLE) && (w_div_nxt >= DIV_HALF);
            r_frame_done <= w_frame_end;
            if (w_tick) begin
                r_state    <= w_state_n;
                r_byte_cnt <= w_byte_n;
                r_line_cnt <= w_line_n;
                r_phase    <= w_phase_n;
                if (w_new_frame)
                    r_mode_q <= cam.mode;
                r_vsync    <= (w_state_n == S_VSYNC);
                r_href     <= w_href_n;
                r_data     <= w_data_n;
                r_line_idx <= (w_state_n == S_ACTIVE) ? w_line_n[9:0] : 10'd0;
            end
        end
    end

    assign cam.cam_pclk   = r_pclk;
    assign cam.cam_vsync  = r_vsync;
    assign cam.cam_href   = r_href;
    assign cam.cam_data   = r_data;
    assign cam.line_idx   = r_line_idx;
    assign cam.frame_done = r_frame_done;
endmodule

// File: tb/tb_camera_timing_gen.sv
// Bench for camera_timing_gen on a small frame: per-byte frame model, mode/en latching, idle and mid-frame reset.
module tb_camera_timing_gen;
    localparam int W        = 4;
    localparam int H        = 3;
    localparam int BPP      = 2;
    localparam int HB       = 2;
    localparam int VS       = 1;
    localparam int VBP      = 1;
    localparam int VFP      = 1;
    localparam int DIV      = 2;
    localparam int LB       = W * BPP + HB;
    localparam int NLINES   = VS + VBP + H + VFP;
    localparam int NBYTES   = LB * NLINES;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [7:0] seq5 [5] = '{8'hAA, 8'h0B, 8'hAC, 8'h0D, 8'hAE};

    camera_timing_gen_if cam_if ();

    camera_timing_gen #(
        .WIDTH(W), .HEIGHT(H), .BPP(BPP), .HBLANK(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .PCLK_DIV(DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cam (cam_if)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] all_outs();
        return {cam_if.cam_pclk, cam_if.cam_vsync, cam_if.cam_href,
                cam_if.cam_data, cam_if.line_idx, cam_if.frame_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_vsync(input int budget);
        int n;
        n = 0;
        while (cam_if.cam_vsync !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("vsync_start", {31'd0, cam_if.cam_vsync}, 32'd1);
    endtask

    // Walks one frame byte by byte from the first vsync-high sample; expected values
    // come from the frame geometry: line = k / LB, byte = k % LB.
    task automatic check_frame(input int m, input int chg_k, input logic [1:0] nm,
                               input logic ne, input int rst_k, output bit aborted);
        int         ph;
        int         line;
        int         b;
        int         a;
        logic       act;
        logic       hr;
        logic       vs;
        logic [7:0] d;
        logic [9:0] idx;
        ph      = 0;
        aborted = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            line = k / LB;
            b    = k % LB;
            a    = line - VS - VBP;
            act  = (a >= 0) && (a < H);
            vs   = (line < VS);
            hr   = act && (b < W * BPP);
            idx  = act ? 10'(a) : 10'd0;
            d    = 8'h00;
            if (hr) begin
                case (m)
                    0:       d = 8'hFF;
                    1:       d = seq5[ph];
                    2:       d = 8'(b);
                    default: d = 8'(a) ^ 8'(b);
                endcase
            end
            for (int s = 0; s < 2; s++) begin
                if (!(k == 0 && s == 0)) @(negedge clk);
                chk("frame_sig", {12'd0, cam_if.cam_vsync, cam_if.cam_href, cam_if.cam_data, cam_if.line_idx},
                    {12'd0, vs, hr, d, idx});
                chk("pclk", {31'd0, cam_if.cam_pclk}, (s == 1) ? 32'd1 : 32'd0);
                if (!(k == 0 && s == 0))
                    chk("fdone_mid", {31'd0, cam_if.frame_done}, 32'd0);
                if (k == rst_k && s == 0) begin
                    rst     = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                if (k == chg_k && s == 0) begin
                    cam_if.mode = nm;
                    cam_if.en   = ne;
                end
            end
            if (hr && m == 1) ph = (ph + 1) % 5;
        end
    endtask

    task automatic end_frame(input logic next_vsync);
        @(negedge clk);
        chk("frame_done", {31'd0, cam_if.frame_done}, 32'd1);
        chk("next_vsync", {31'd0, cam_if.cam_vsync}, {31'd0, next_vsync});
    endtask

    initial begin
        bit         ab;
        logic [1:0] rm;
        rst         = 1'b1;
        cam_if.en   = 1'b0;
        cam_if.mode = 2'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {10'd0, all_outs()}, 32'd0);
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            chk("idle_outs", {10'd0, all_outs()}, 32'd0);
        end

        // Mode 0 from idle; switch to seq5 mid-ACTIVE, which only takes effect next frame.
        cam_if.en = 1'b1;
        wait_vsync(10);
        check_frame(0, 35, 2'd1, 1'b1, -1, ab);
        end_frame(1'b1);
        check_frame(1, int'($urandom_range(NBYTES - 1, 1)), 2'd1, 1'b1, -1, ab);
        end_frame(1'b1);
        check_frame(1, int'($urandom_range(NBYTES - 1, 1)), 2'd2, 1'b1, -1, ab);
        end_frame(1'b1);
        check_frame(2, int'($urandom_range(NBYTES - 1, 1)), 2'd3, 1'b1, -1, ab);
        end_frame(1'b1);
        check_frame(3, 25, 2'd0, 1'b1, -1, ab);
        end_frame(1'b1);

        // Drop en and move to ramp mid-ACTIVE: frame stays FF, completes, then idles.
        check_frame(0, 35, 2'd2, 1'b0, -1, ab);
        end_frame(1'b0);
        repeat (100) begin
            @(negedge clk);
            chk("idle_after_en", {10'd0, all_outs()}, 32'd0);
        end

        rm = 2'($urandom_range(3, 0));
        cam_if.en = 1'b1;
        wait_vsync(10);
        check_frame(2, int'($urandom_range(NBYTES - 1, 1)), rm, 1'b1, -1, ab);
        end_frame(1'b1);

        // Reset in active line 1, then a fresh seq5 frame must start at AA.
        check_frame(int'(rm), 10, 2'd1, 1'b1, 33, ab);
        chk("rst_aborted", {31'd0, ab}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_outs", {10'd0, all_outs()}, 32'd0);
        end
        rst = 1'b0;
        wait_vsync(10);
        check_frame(1, -1, 2'd1, 1'b1, -1, ab);
        end_frame(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
